// File: rtl/td_tap_monitor.sv
// td_tap_monitor: measures ref-edge to tap delays of a 5-tap delay line.
// Optional stats block enabled by defining TD_TAP_MONITOR_STATS_EN.
module td_tap_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ref_in,
  input  logic [4:0]         tap_in,
`ifdef TD_TAP_MONITOR_STATS_EN
  input  logic               stats_clr,
  output logic [CNT_W-1:0]   dly4_min,
  output logic [CNT_W-1:0]   dly4_max,
  output logic [15:0]        meas_count,
`endif
  output logic               meas_valid,
  output logic               meas_pol,
  output logic [5*CNT_W-1:0] dly_out,
  output logic               err_order,
  output logic               err_timeout,
  output logic               err_abort,
  output logic               busy
);

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, MEAS, REPORT} state_t;

  state_t state;
  state_t state_nxt;

  logic       ref_q1;
  logic       ref_s;
  logic       ref_d;
  logic [4:0] tap_q1;
  logic [4:0] tap_s;

  logic                  pol;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_inc;
  logic [4:0]            seen;
  logic [4:0]            hit;
  logic [4:0]            seen_fin;
  logic [4:0][CNT_W-1:0] dly;
  logic [4:0][CNT_W-1:0] dly_fin;

  logic ref_edge;
  logic done;
  logic tmo;
  logic order;
  logic fin;

  // Two-flop synchronisers plus one-cycle delayed ref for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ref_q1 <= 1'b0;
      ref_s  <= 1'b0;
      ref_d  <= 1'b0;
      tap_q1 <= '0;
      tap_s  <= '0;
    end else begin
      ref_q1 <= ref_in;
      ref_s  <= ref_q1;
      ref_d  <= ref_s;
      tap_q1 <= tap_in;
      tap_s  <= tap_q1;
    end
  end

  // Per-cycle measurement arithmetic: new hits, final delays, order check
  always_comb begin
    ref_edge = (ref_s != ref_d);
    cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
    hit      = '0;
    for (int k = 0; k < 5; k++) begin
      hit[k] = !seen[k] && (tap_s[k] == pol);
    end
    seen_fin = seen | hit;
    done     = &seen_fin;
    tmo      = (cnt_inc == TO);
    dly_fin  = dly;
    for (int k = 0; k < 5; k++) begin
      if (hit[k]) begin
        dly_fin[k] = cnt_inc;
      end
    end
    if (!ref_edge && !done && tmo) begin
      for (int k = 0; k < 5; k++) begin
        if (!seen_fin[k]) begin
          dly_fin[k] = '1;
        end
      end
    end
    order = 1'b0;
    for (int k = 1; k < 5; k++) begin
      if (seen_fin[k] && seen_fin[k-1] && (dly_fin[k] < dly_fin[k-1])) begin
        order = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; abort, completion and timeout all end MEAS
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ref_edge) state_nxt = MEAS;
      MEAS:    if (ref_edge || done || tmo) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy flag and end-of-measurement strobe
  always_comb begin
    busy = (state != IDLE);
    fin  = (state == MEAS) && (state_nxt == REPORT);
  end

  // Measurement datapath: arm on a ref edge, accumulate tap arrivals
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pol  <= 1'b0;
      cnt  <= '0;
      seen <= '0;
      dly  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ref_edge) begin
            pol  <= ref_s;
            cnt  <= '0;
            seen <= ~(tap_s ^ {5{ref_s}});
            dly  <= '0;
          end
        end
        MEAS: begin
          cnt  <= cnt_inc;
          seen <= seen_fin;
          dly  <= dly_fin;
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded on entry to REPORT and held until the next one
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meas_valid  <= 1'b0;
      meas_pol    <= 1'b0;
      dly_out     <= '0;
      err_order   <= 1'b0;
      err_timeout <= 1'b0;
      err_abort   <= 1'b0;
    end else begin
      meas_valid <= fin;
      if (fin) begin
        meas_pol    <= pol;
        dly_out     <= dly_fin;
        err_order   <= order;
        err_timeout <= !ref_edge && !done && tmo;
        err_abort   <= ref_edge;
      end
    end
  end

`ifdef TD_TAP_MONITOR_STATS_EN
  // Tap-4 min/max tracking and report counter; clear beats update
  always_ff @(posedge clk) begin
    if (!reset_n || stats_clr) begin
      dly4_min   <= '1;
      dly4_max   <= '0;
      meas_count <= '0;
    end else if (fin) begin
      if (meas_count != 16'hFFFF) begin
        meas_count <= meas_count + 16'd1;
      end
      if (seen_fin[4] && !ref_edge) begin
        if (dly_fin[4] < dly4_min) dly4_min <= dly_fin[4];
        if (dly_fin[4] > dly4_max) dly4_max <= dly_fin[4];
      end
    end
  end
`endif

endmodule
